// File: rtl/rr_onehot_arbiter_if.sv
// Handshake bundle between the round-robin arbiter and its grant consumer.
// Carries grant_idx only when RR_ARB_IDX_EN is defined.
interface rr_onehot_arbiter_if #(
    parameter int WIDTH = 4
);
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [WIDTH-1:0] req;
    logic [WIDTH-1:0] grant;
    logic             grant_valid;
    logic             grant_ack;
`ifdef RR_ARB_IDX_EN
    logic [IW-1:0]    grant_idx;
`endif

    modport master (
        input  req,
        input  grant_ack,
        output grant,
        output grant_valid
`ifdef RR_ARB_IDX_EN
        , output grant_idx
`endif
    );

    modport slave (
        output req,
        output grant_ack,
        input  grant,
        input  grant_valid
`ifdef RR_ARB_IDX_EN
        , input grant_idx
`endif
    );
endinterface

// File: rtl/rr_onehot_arbiter.sv
// Round-robin arbiter with a registered one-hot grant held under valid/ack.
// Optional feature macro RR_ARB_IDX_EN adds a registered binary grant_idx output.
module rr_onehot_arbiter #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    rr_onehot_arbiter_if.master  bus
);
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic {IDLE, BUSY} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] grant_q, grant_d;
    logic [IW-1:0]    idx_q,   idx_d;
    logic [IW-1:0]    ptr_q,   ptr_d;

    logic [IW-1:0]    next_ptr;
    logic [IW-1:0]    scan_ptr;
    logic [WIDTH-1:0] rot;
    logic [WIDTH-1:0] pick;
    logic [IW-1:0]    pick_idx;
    logic             found;
    int               pos;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            idx_q   <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
        end
    end

    // An acked grant re-arbitrates on the same edge, so the scan must already use the advanced pointer.
    always_comb begin
        next_ptr = (int'(idx_q) == WIDTH - 1) ? '0 : idx_q + IW'(1);
        scan_ptr = (state_q == BUSY) ? next_ptr : ptr_q;
        rot      = WIDTH'({bus.req, bus.req} >> scan_ptr);
        found    = 1'b0;
        pick_idx = '0;
        pos      = 0;
        for (int k = 0; k < WIDTH; k++) begin
            if (!found && rot[k]) begin
                found = 1'b1;
                pos   = int'(scan_ptr) + k;
                if (pos >= WIDTH) pos = pos - WIDTH;
                pick_idx = IW'(pos);
            end
        end
        pick = found ? (WIDTH'(1) << pick_idx) : '0;
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    grant_d = pick;
                    idx_d   = pick_idx;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (bus.grant_ack) begin
                    ptr_d = next_ptr;
                    if (found) begin
                        grant_d = pick;
                        idx_d   = pick_idx;
                    end else begin
                        grant_d = '0;
                        idx_d   = '0;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.grant       = grant_q;
        bus.grant_valid = (state_q == BUSY);
`ifdef RR_ARB_IDX_EN
        bus.grant_idx   = idx_q;
`endif
    end
endmodule

// File: tb/tb_rr_onehot_arbiter.sv
// Scoreboard bench for rr_onehot_arbiter at WIDTH=4: a cycle model queues
// expected outputs as stimulus is driven, a monitor pops and compares them.
module tb_rr_onehot_arbiter;
    localparam int W = 4;

    typedef struct {
        logic [W-1:0] grant;
        logic         valid;
        logic [1:0]   idx;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   tests_run    = 0;
    int   tests_failed = 0;

    exp_t sb[$];
    exp_t mon_e;

    int m_valid;
    int m_idx;
    int m_ptr;

    rr_onehot_arbiter_if #(.WIDTH(W)) bus ();

    rr_onehot_arbiter #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, actual, expected, $time);
        end
    endtask

    function automatic int modelPick(input logic [W-1:0] r, input int p);
        for (int off = 0; off < W; off++) begin
            if (r[(p + off) % W]) return (p + off) % W;
        end
        return -1;
    endfunction

    // Drive one cycle of inputs, advance the reference model, and queue what the DUT must show after the edge.
    task automatic applyStimulus(input logic [W-1:0] r, input logic a, input logic rs);
        int   p;
        exp_t e;
        @(negedge clk);
        bus.req       = r;
        bus.grant_ack = a;
        rst           = rs;
        if (rs) begin
            m_valid = 0;
            m_idx   = 0;
            m_ptr   = 0;
        end else if (m_valid == 0) begin
            p = modelPick(r, m_ptr);
            if (p >= 0) begin
                m_valid = 1;
                m_idx   = p;
            end
        end else if (a) begin
            m_ptr = (m_idx + 1) % W;
            p = modelPick(r, m_ptr);
            if (p >= 0) m_idx = p;
            else begin
                m_valid = 0;
                m_idx   = 0;
            end
        end
        e.valid = (m_valid != 0);
        e.grant = e.valid ? W'(1 << m_idx) : '0;
        e.idx   = 2'(m_idx);
        sb.push_back(e);
    endtask

    always @(posedge clk) begin
        #1;
        if (sb.size() != 0) begin
            mon_e = sb.pop_front();
            checkOutput("grant", 32'(bus.grant), 32'(mon_e.grant));
            checkOutput("grant_valid", 32'(bus.grant_valid), 32'(mon_e.valid));
            checkOutput("onehot0", 32'($onehot0(bus.grant)), 32'd1);
`ifdef RR_ARB_IDX_EN
            checkOutput("grant_idx", 32'(bus.grant_idx), 32'(mon_e.idx));
`endif
        end
    end

    initial begin
        rst           = 1'b1;
        bus.req       = '0;
        bus.grant_ack = 1'b0;
        m_valid = 0;
        m_idx   = 0;
        m_ptr   = 0;

        // Reset with all requests pending, then release
        applyStimulus(4'b1111, 1'b0, 1'b1);
        applyStimulus(4'b1111, 1'b0, 1'b1);
        applyStimulus(4'b1111, 1'b0, 1'b0);

        // Rotation with continuous ack, including wrap
        for (int i = 0; i < 5; i++) applyStimulus(4'b1111, 1'b1, 1'b0);

        // Hold on 0100 while req changes, then ack skips to 0001
        applyStimulus(4'b0000, 1'b0, 1'b1);
        applyStimulus(4'b0100, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) applyStimulus(4'b0011, 1'b0, 1'b0);
        applyStimulus(4'b0011, 1'b1, 1'b0);

        // Sole requester is re-granted each cycle
        for (int i = 0; i < 4; i++) applyStimulus(4'b0010, 1'b1, 1'b0);

        // Drain to idle, then ack pulses while idle
        applyStimulus(4'b0001, 1'b1, 1'b0);
        applyStimulus(4'b0000, 1'b1, 1'b0);
        applyStimulus(4'b0000, 1'b1, 1'b0);
        applyStimulus(4'b0000, 1'b0, 1'b0);
        applyStimulus(4'b0000, 1'b1, 1'b0);

        // Reset while holding 1000
        applyStimulus(4'b0000, 1'b0, 1'b1);
        applyStimulus(4'b1000, 1'b0, 1'b0);
        applyStimulus(4'b1000, 1'b0, 1'b0);
        applyStimulus(4'b1000, 1'b1, 1'b1);
        applyStimulus(4'b1111, 1'b0, 1'b0);
        applyStimulus(4'b1111, 1'b0, 1'b0);

        // Random traffic with occasional resets
        for (int i = 0; i < 300; i++) begin
            applyStimulus(W'($urandom_range(0, 15)),
                          1'($urandom_range(0, 1)),
                          ($urandom_range(0, 31) == 0));
        end

        @(posedge clk);
        #2;
        checkOutput("sb_drain", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
